// File: rtl/kamus_wb_pkg.sv
// kamus_wb_pkg: shared types for the kamus-v writeback stage.
//   wb_sel_e    : result source select encoding (slot index into src_data_i)
//   ld_size_e   : load access size
//   wb_state_e  : writeback FSM state
//   ld_size_bits: number of significant bits a load of a given size returns
package kamus_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_BYTE   = 2'd0,
    LD_HALF   = 2'd1,
    LD_WORD   = 2'd2,
    LD_DOUBLE = 2'd3
  } ld_size_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_WAIT_LD = 1'b1
  } wb_state_e;

  // A double on a 32-bit datapath degrades to a word.
  function automatic logic [6:0] ld_size_bits(input ld_size_e size, input int xlen);
    logic [6:0] bits;
    case (size)
      LD_BYTE: bits = 7'd8;
      LD_HALF: bits = 7'd16;
      LD_WORD: bits = 7'd32;
      default: bits = (xlen == 64) ? 7'd64 : 7'd32;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/kamus_wb_load_align.sv
// kamus_wb_load_align: combinational load-data aligner / extender.
// Ports:
//   data          in  XLEN            raw naturally aligned L1D word
//   size          in  ld_size_e       access size
//   load_unsigned in  1               zero-extend instead of sign-extend
//   offset        in  $clog2(XLEN/8)  byte offset of the load address
//   result        out XLEN            aligned, extended load value
// Offset bits below the access granule are ignored; misaligned accesses
// never reach this block.
module kamus_wb_load_align
  import kamus_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           data,
  input  ld_size_e                  size,
  input  logic                      load_unsigned,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  output logic [XLEN-1:0]           result
);

  localparam int OFF_W = $clog2(XLEN/8);

  logic [OFF_W-1:0] eff_off;
  logic [XLEN-1:0]  lane;
  logic [XLEN-1:0]  up;
  logic [6:0]       sh;

  always_comb begin
    // Clear the offset bits that fall inside the access granule.
    case (size)
      LD_BYTE:   eff_off = offset;
      LD_HALF:   eff_off = offset & ~OFF_W'(1);
      LD_WORD:   eff_off = offset & ~OFF_W'(3);
      LD_DOUBLE: eff_off = '0;
      default:   eff_off = '0;
    endcase

    lane = data >> {eff_off, 3'b000};

    // Move the field to the top, then shift back logically or arithmetically
    // to get zero or sign extension for any field width.
    sh = 7'(XLEN) - ld_size_bits(size, XLEN);
    up = lane << sh;
    if (load_unsigned) begin
      result = up >> sh;
    end else begin
      result = $signed(up) >>> sh;
    end
  end

endmodule

// File: rtl/kamus_wb_stage.sv
// kamus_wb_stage: writeback stage of the kamus-v core.
// Accepts one retiring instruction per cycle from MEM/WB, picks its result
// source, waits for late L1D load data, and drives a registered
// register-file write port plus a retired-instruction counter.
//
// Handshake: an instruction transfers on a cycle where memwb_valid_i and
// memwb_ready_o are both high. memwb_ready_o is decoded from FSM state only
// (high in S_IDLE), so it never depends combinationally on any input.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   memwb_valid_i/ready_o   instruction handshake
//   regfile_wr_en_i         instruction writes rd
//   rd_addr_i               destination register
//   wb_mux_sel_i            result source (wb_sel_e)
//   src_data_i              packed sources, slot k at [k*XLEN +: XLEN]
//   load_size_i             0 byte, 1 half, 2 word, 3 double
//   load_unsigned_i         zero-extend load result
//   load_offset_i           byte offset of the load address
//   l1d_rsp_valid_i/data_i  L1D read response
//   rf_wr_en_o/addr_o/data_o registered register-file write port
//   ld_busy_o/ld_busy_addr_o load outstanding and its rd
//   rsp_err_o               sticky: L1D response with no load pending
//   instret_o               retired-instruction count (wraps)
module kamus_wb_stage
  import kamus_wb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_SRC   = 4,
  parameter int REG_AW    = 5,
  parameter int INSTRET_W = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       memwb_valid_i,
  output logic                       memwb_ready_o,
  input  logic                       regfile_wr_en_i,
  input  logic [REG_AW-1:0]          rd_addr_i,
  input  logic [$clog2(NUM_SRC)-1:0] wb_mux_sel_i,
  input  logic [NUM_SRC*XLEN-1:0]    src_data_i,
  input  logic [1:0]                 load_size_i,
  input  logic                       load_unsigned_i,
  input  logic [$clog2(XLEN/8)-1:0]  load_offset_i,
  input  logic                       l1d_rsp_valid_i,
  input  logic [XLEN-1:0]            l1d_rsp_data_i,
  output logic                       rf_wr_en_o,
  output logic [REG_AW-1:0]          rf_wr_addr_o,
  output logic [XLEN-1:0]            rf_wr_data_o,
  output logic                       ld_busy_o,
  output logic [REG_AW-1:0]          ld_busy_addr_o,
  output logic                       rsp_err_o,
  output logic [INSTRET_W-1:0]       instret_o
);

  localparam int OFF_W = $clog2(XLEN/8);

  wb_state_e         state;
  wb_state_e         state_next;

  // Load context captured at accept time, consumed when data returns.
  logic [REG_AW-1:0] lat_rd;
  logic              lat_we;
  ld_size_e          lat_size;
  logic              lat_uns;
  logic [OFF_W-1:0]  lat_off;

  logic              accept;
  logic              is_load_sel;
  logic              ld_done;
  logic [XLEN-1:0]   sel_data;
  logic [XLEN-1:0]   ld_result;

  assign accept      = memwb_valid_i && memwb_ready_o;
  assign is_load_sel = (int'(wb_mux_sel_i) == int'(WB_LOAD));
  // A response in the accept cycle is not sampled: state is still S_IDLE.
  assign ld_done     = (state == S_WAIT_LD) && l1d_rsp_valid_i;

  // Source select. The load slot is never used here and out-of-range
  // selects fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if ((int'(wb_mux_sel_i) == k) && (k != int'(WB_LOAD))) begin
        sel_data = src_data_i[k*XLEN +: XLEN];
      end
    end
  end

  kamus_wb_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .data          (l1d_rsp_data_i),
    .size          (lat_size),
    .load_unsigned (lat_uns),
    .offset        (lat_off),
    .result        (ld_result)
  );

  // FSM: state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && is_load_sel) begin
          state_next = S_WAIT_LD;
        end
      end
      S_WAIT_LD: begin
        if (l1d_rsp_valid_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: state-decoded outputs.
  always_comb begin
    memwb_ready_o  = (state == S_IDLE);
    ld_busy_o      = (state == S_WAIT_LD);
    ld_busy_addr_o = (state == S_WAIT_LD) ? lat_rd : '0;
  end

  // Load context capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_rd   <= '0;
      lat_we   <= 1'b0;
      lat_size <= LD_BYTE;
      lat_uns  <= 1'b0;
      lat_off  <= '0;
    end else if (accept && is_load_sel) begin
      lat_rd   <= rd_addr_i;
      lat_we   <= regfile_wr_en_i;
      lat_size <= ld_size_e'(load_size_i);
      lat_uns  <= load_unsigned_i;
      lat_off  <= load_offset_i;
    end
  end

  // Write port and retirement counter. The write slot is the cycle after a
  // non-load accept or after a load response; outside it the port is zero.
  // Writes to x0 or with the enable low still retire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_wr_en_o   <= 1'b0;
      rf_wr_addr_o <= '0;
      rf_wr_data_o <= '0;
      instret_o    <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      rf_wr_en_o   <= 1'b0;
      rf_wr_addr_o <= '0;
      rf_wr_data_o <= '0;
      if (accept && !is_load_sel) begin
        rf_wr_en_o   <= regfile_wr_en_i && (rd_addr_i != '0);
        rf_wr_addr_o <= rd_addr_i;
        rf_wr_data_o <= sel_data;
        instret_o    <= instret_o + INSTRET_W'(1);
      end else if (ld_done) begin
        rf_wr_en_o   <= lat_we && (lat_rd != '0);
        rf_wr_addr_o <= lat_rd;
        rf_wr_data_o <= ld_result;
        instret_o    <= instret_o + INSTRET_W'(1);
      end
      // A response with no load pending carries no data we can use.
      if ((state == S_IDLE) && l1d_rsp_valid_i) begin
        rsp_err_o <= 1'b1;
      end
    end
  end

endmodule
